// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised RX line, mid-bit start qualification, centre sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err
);

    localparam logic [8:0] HALF = 9'((CLKS_PER_BIT - 1) >> 1);
    localparam logic [8:0] LAST = 9'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3,
                              CLEANUP = 3'd4, PARITY = 3'd5} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3,
                              CLEANUP = 3'd4} state_t;
`endif

    state_t     r_State, state_nxt;
    logic       r_Rx_m, r_Rx, r_Rx_d;
    logic [8:0] r_Clock_Count, count_nxt;
    logic [2:0] r_Bit_Index, idx_nxt;
    logic [7:0] r_Shift, shift_nxt, byte_nxt;
    logic       active_nxt, dv_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic       r_Par_Bit, par_nxt, perr_nxt, r_Parity_Err;

    // Even parity: the XOR of the data bits must equal the received parity bit.
    function automatic logic parity_bad(input logic [7:0] data, input logic par);
        return (^data) != par;
    endfunction

    assign o_Parity_Err = r_Parity_Err;
`else
    assign o_Parity_Err = 1'b0;
`endif

    // Synchronisers reset to 1 so a released reset never looks like a start edge on an idle line.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Rx_m <= 1'b1;
            r_Rx   <= 1'b1;
            r_Rx_d <= 1'b1;
        end else begin
            r_Rx_m <= i_Rx_Serial;
            r_Rx   <= r_Rx_m;
            r_Rx_d <= r_Rx;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State       <= IDLE;
            r_Clock_Count <= '0;
            r_Bit_Index   <= '0;
            r_Shift       <= '0;
            o_Rx_Byte     <= '0;
            o_Rx_Active   <= 1'b0;
            o_Rx_DV       <= 1'b0;
            o_Frame_Err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_Par_Bit     <= 1'b0;
            r_Parity_Err  <= 1'b0;
`endif
        end else begin
            r_State       <= state_nxt;
            r_Clock_Count <= count_nxt;
            r_Bit_Index   <= idx_nxt;
            r_Shift       <= shift_nxt;
            o_Rx_Byte     <= byte_nxt;
            o_Rx_Active   <= active_nxt;
            o_Rx_DV       <= dv_nxt;
            o_Frame_Err   <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_Par_Bit     <= par_nxt;
            r_Parity_Err  <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = r_State;
        count_nxt  = r_Clock_Count;
        idx_nxt    = r_Bit_Index;
        shift_nxt  = r_Shift;
        byte_nxt   = o_Rx_Byte;
        active_nxt = o_Rx_Active;
        dv_nxt     = 1'b0;
        ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt    = r_Par_Bit;
        perr_nxt   = 1'b0;
`endif
        case (r_State)
            IDLE: begin
                count_nxt = '0;
                idx_nxt   = '0;
                if (r_Rx_d && !r_Rx)
                    state_nxt = START;
            end
            START: begin
                if (r_Clock_Count == HALF) begin
                    count_nxt = '0;
                    if (!r_Rx) begin
                        active_nxt = 1'b1;
                        state_nxt  = DATA;
                    end else begin
                        state_nxt  = IDLE;
                    end
                end else begin
                    count_nxt = r_Clock_Count + 9'd1;
                end
            end
            DATA: begin
                if (r_Clock_Count == LAST) begin
                    count_nxt              = '0;
                    shift_nxt[r_Bit_Index] = r_Rx;
                    idx_nxt                = r_Bit_Index + 3'd1;
                    if (r_Bit_Index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    count_nxt = r_Clock_Count + 9'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_Clock_Count == LAST) begin
                    count_nxt = '0;
                    par_nxt   = r_Rx;
                    state_nxt = STOP;
                end else begin
                    count_nxt = r_Clock_Count + 9'd1;
                end
            end
`endif
            STOP: begin
                if (r_Clock_Count == LAST) begin
                    count_nxt = '0;
                    state_nxt = CLEANUP;
                    // A bad stop bit outranks a parity mismatch.
                    if (!r_Rx) begin
                        ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad(r_Shift, r_Par_Bit)) begin
                        perr_nxt = 1'b1;
`endif
                    end else begin
                        dv_nxt   = 1'b1;
                        byte_nxt = r_Shift;
                    end
                end else begin
                    count_nxt = r_Clock_Count + 9'd1;
                end
            end
            CLEANUP: begin
                active_nxt = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                count_nxt  = '0;
                idx_nxt    = '0;
                active_nxt = 1'b0;
            end
        endcase
    end

endmodule
